event_router_rr: RTL and testbench
==================================

// Module: event_router_rr
// PURPOSE
//  Parametrised successor event router: collects events from NUMCHANNELS local channel FIFOs and routes them one
//  at a time to the shared chip FIFO. Adds a per-channel enable mask, shared-FIFO backpressure, round-robin
//  arbitration and a saturating dropped-event counter. Sits between the channel FIFOs and the shared FIFO.
//  LightPix mode integrates hits over a timeout window; below-threshold windows are flushed.
// PARAMETERS
//  WIDTH        64                      event word width incl. parity; routed word is WIDTH-1 bits
//  NUMCHANNELS  64                      number of channels (2..128)
//  HITW         $clog2(NUMCHANNELS+1)   width of hit count and hit_threshold
//  TIMERW       8                       width of timeout and integration timer
//  WAIT_CYCLES  3                       settle cycles after each load (>=1)
// PORTS
//  clk                clock   in   1               master clock
//  reset_n            reset   in   1               asynchronous digital reset, active low
//  input_event        in   [WIDTH-2:0] x NUMCH     per-channel FIFO head data
//  local_fifo_empty   in   NUMCHANNELS             high = channel FIFO empty
//  channel_mask       in   NUMCHANNELS             high = channel enabled
//  lightpix_mode      in   1                       1 = integrate and threshold; 0 = accept immediately
//  hit_threshold      in   HITW                    hits needed to accept; 0 is treated as 1
//  timeout            in   TIMERW                  integration window length, in clk cycles
//  shared_fifo_full   in   1                       backpressure from the shared FIFO
//  channel_event_out  out  [WIDTH-2:0]             routed event (pre-parity)
//  load_event         out  1                       one-cycle write strobe to the shared FIFO
//  read_local_fifo_n  out  NUMCHANNELS             active-low pop strobe, one per channel
//  busy               out  1                       high whenever state is not IDLE
//  dropped_events     out  16                      saturating count of flushed windows
// BEHAVIOUR
//  - Reset values: channel_event_out=0, load_event=0, read_local_fifo_n=all 1, busy=0, dropped_events=0, state=IDLE.
//  - Reset is asynchronous and may assert mid-operation. It aborts any event. No pop or load is issued afterwards.
//  - All outputs are registered and decoded from the next state.
//  - pending = ~local_fifo_empty & channel_mask. hits = popcount(pending), computed in HITW bits.
//  - Masked channels are never counted and never popped.
//  - IDLE: if pending != 0, go to INTEGRATE and clear timer.
//  - INTEGRATE: timer increments each cycle.
//      - mode 0: go to SELECT next cycle.
//      - mode 1, hits >= max(hit_threshold,1): go to SELECT. This check has priority over the timeout.
//      - mode 1, otherwise when timer >= timeout: go to FLUSH.
//  - SELECT: hold <= pending snapshot. Grant is chosen from hold (see CONFIGURATION).
//      - Channels that become non-empty after the snapshot wait for the next window.
//  - READ: read_local_fifo_n[grant] low for exactly one cycle. hold[grant] cleared.
//  - LATCH: channel_event_out <= input_event[grant].
//      - If shared_fifo_full: stay in LATCH, hold the data, keep load_event low.
//      - Else: load_event high for one cycle with the data valid in the same cycle.
//  - WAIT: stay WAIT_CYCLES cycles.
//      - Then go to SELECT-grant -> READ if hold != 0, else go to IDLE.
//  - FLUSH: read_local_fifo_n <= ~hold_snapshot of pending for one cycle.
//      - dropped_events increments and saturates at 16'hFFFF. Then go to IDLE.
//  - Latency, mode 0, idle router: empty falls in cycle 0, pop strobe in cycle 3, load_event in cycle 4.
//  - A channel that empties before its grant is skipped: it is cleared from hold without a pop or a load.
//  - timeout=0 in mode 1: flush after one INTEGRATE cycle unless the threshold is already met.
// CONFIGURATION
//  - MADCAP_ROUTER_RR_EN defined: round-robin arbitration.
//      - Search starts at last_grant+1 and wraps modulo NUMCHANNELS.
//      - last_grant persists across events and resets to NUMCHANNELS-1.
//  - Not defined: fixed priority, lowest index first. No last_grant register.
//  - Ports are identical in both builds.
// STRUCTURE
//  - madcap_router_pkg holds:
//      - router_state_t enum: IDLE, INTEGRATE, SELECT, READ, LATCH, WAIT, FLUSH.
//      - popcount function.
//      - DROP_CNT_W=16.
//  - Sub-module router_arbiter: request vector + last_grant in; one-hot grant and index out; combinational;
//    contains the RR/fixed-priority ifdef.
//  - The top level holds the FSM, timer, hold register, data mux and counter.
// TESTING
//  - mode 0, ch5 and ch9 non-empty, mask all 1 -> pops ch5 then ch9, two load_event pulses, data matches.
//  - mode 1, threshold 3, timeout 10, two channels non-empty -> FLUSH after 11 cycles.
//      - Both channels popped once, dropped_events=1, no load_event.
//  - mode 1, threshold 3, third channel arrives at cycle 4 -> accepted; three loads, no drop.
//  - mask[5]=0 with ch5 non-empty -> router stays IDLE, read_local_fifo_n[5] never low.
//  - shared_fifo_full held for 20 cycles in LATCH -> data stable, load_event low.
//      - One load on release.
//  - RR build, ch0 always pending, ch7 pending -> grants alternate 0,7,0,7 across events.
//      - Fixed build -> ch0 first every event.
//  - reset_n low mid-LATCH -> all outputs at reset values immediately, state IDLE.

Source files
------------

// File: rtl/madcap_router_pkg.sv
// Shared types and helpers for the event router: FSM state encoding, popcount and counter width.
package madcap_router_pkg;

  localparam int DROP_CNT_W   = 16;
  localparam int MAX_CHANNELS = 128;

  typedef enum logic [2:0] {
    IDLE,
    INTEGRATE,
    SELECT,
    READ,
    LATCH,
    WAIT,
    FLUSH
  } router_state_t;

  // Callers zero-extend their request vector to MAX_CHANNELS bits.
  function automatic int unsigned popcount(input logic [MAX_CHANNELS-1:0] vec);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MAX_CHANNELS; i++) begin
      cnt = cnt + 32'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/router_arbiter.sv
// Combinational channel arbiter: one-hot grant plus index from a request vector.
// MADCAP_ROUTER_RR_EN selects round-robin from last_grant+1; otherwise lowest index wins.
module router_arbiter #(
  parameter int NUMCHANNELS = 64,
  parameter int IDXW        = $clog2(NUMCHANNELS)
) (
  input  logic [NUMCHANNELS-1:0] request,
  input  logic [IDXW-1:0]        last_grant,
  output logic [NUMCHANNELS-1:0] grant,
  output logic [IDXW-1:0]        grant_idx,
  output logic                   grant_valid
);

  logic found;

`ifdef MADCAP_ROUTER_RR_EN
  logic [IDXW-1:0] cand;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NUMCHANNELS; k++) begin
      cand = IDXW'((int'(last_grant) + k) % NUMCHANNELS);
      if (!found && request[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  // Scan downwards so the lowest requesting index is the last one written.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int k = NUMCHANNELS - 1; k >= 0; k--) begin
      if (request[k]) begin
        found     = 1'b1;
        grant_idx = IDXW'(k);
      end
    end
  end
`endif

  assign grant_valid = found;
  assign grant       = found ? (NUMCHANNELS'(1) << grant_idx) : '0;

endmodule

// File: rtl/event_router_rr.sv
// Event router: collects channel FIFO heads and writes them one at a time into the shared FIFO.
// Build with MADCAP_ROUTER_RR_EN for round-robin grants; default build uses fixed priority.
module event_router_rr
  import madcap_router_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int NUMCHANNELS = 64,
  parameter int HITW        = $clog2(NUMCHANNELS + 1),
  parameter int TIMERW      = 8,
  parameter int WAIT_CYCLES = 3
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUMCHANNELS-1:0][WIDTH-2:0] input_event,
  input  logic [NUMCHANNELS-1:0]            local_fifo_empty,
  input  logic [NUMCHANNELS-1:0]            channel_mask,
  input  logic                              lightpix_mode,
  input  logic [HITW-1:0]                   hit_threshold,
  input  logic [TIMERW-1:0]                 timeout,
  input  logic                              shared_fifo_full,
  output logic [WIDTH-2:0]                  channel_event_out,
  output logic                              load_event,
  output logic [NUMCHANNELS-1:0]            read_local_fifo_n,
  output logic                              busy,
  output logic [DROP_CNT_W-1:0]             dropped_events
);

  localparam int IDXW = (NUMCHANNELS > 1) ? $clog2(NUMCHANNELS) : 1;
  localparam int WCW  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  router_state_t state_reg, state_next;

  logic [NUMCHANNELS-1:0] pending;
  logic [NUMCHANNELS-1:0] hold_reg, hold_next;
  logic [NUMCHANNELS-1:0] arb_req, arb_grant;
  logic [IDXW-1:0]        arb_idx, arb_last, grant_idx_reg;
  logic                   arb_valid;
  logic [HITW-1:0]        hits, thr_eff;
  logic [TIMERW-1:0]      timer_reg;
  logic [WCW-1:0]         wait_cnt_reg;
  logic [WIDTH-2:0]       data_reg;
  logic                   load_reg;
  logic [NUMCHANNELS-1:0] read_n_reg;
  logic                   busy_reg;
  logic [DROP_CNT_W-1:0]  drop_cnt_reg;

  assign pending = ~local_fifo_empty & channel_mask;
  assign hits    = HITW'(popcount(MAX_CHANNELS'(pending)));
  assign thr_eff = (hit_threshold == '0) ? HITW'(1) : hit_threshold;

  // The window is snapshotted in SELECT; afterwards only channels still in hold and still non-empty compete.
  assign arb_req = (state_reg == SELECT) ? pending : (hold_reg & pending);

  router_arbiter #(
    .NUMCHANNELS (NUMCHANNELS),
    .IDXW        (IDXW)
  ) u_arbiter (
    .request     (arb_req),
    .last_grant  (arb_last),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

`ifdef MADCAP_ROUTER_RR_EN
  logic [IDXW-1:0] last_grant_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_reg <= IDXW'(NUMCHANNELS - 1);
    end else if (state_reg == READ) begin
      last_grant_reg <= grant_idx_reg;
    end
  end

  assign arb_last = last_grant_reg;
`else
  assign arb_last = IDXW'(NUMCHANNELS - 1);
`endif

  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    case (state_reg)
      IDLE: begin
        if (|pending) state_next = INTEGRATE;
      end
      INTEGRATE: begin
        if (!lightpix_mode || (hits >= thr_eff)) begin
          state_next = SELECT;
        end else if (timer_reg >= timeout) begin
          state_next = FLUSH;
          hold_next  = pending;
        end
      end
      SELECT: begin
        hold_next  = pending;
        state_next = arb_valid ? READ : IDLE;
      end
      READ: begin
        hold_next[grant_idx_reg] = 1'b0;
        state_next               = LATCH;
      end
      LATCH: begin
        if (load_reg) state_next = WAIT;
      end
      WAIT: begin
        if (wait_cnt_reg == WCW'(WAIT_CYCLES - 1)) begin
          // Channels that drained before their turn drop out of the window here.
          hold_next  = hold_reg & pending;
          state_next = arb_valid ? READ : IDLE;
        end
      end
      FLUSH: begin
        hold_next  = '0;
        state_next = IDLE;
      end
      default: begin
        hold_next  = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_reg      <= '0;
      timer_reg     <= '0;
      wait_cnt_reg  <= '0;
      grant_idx_reg <= '0;
      data_reg      <= '0;
      load_reg      <= 1'b0;
      read_n_reg    <= '1;
      busy_reg      <= 1'b0;
      drop_cnt_reg  <= '0;
    end else begin
      hold_reg <= hold_next;

      if (state_reg == INTEGRATE) begin
        if (timer_reg != {TIMERW{1'b1}}) timer_reg <= timer_reg + TIMERW'(1);
      end else begin
        timer_reg <= '0;
      end

      wait_cnt_reg <= (state_reg == WAIT) ? (wait_cnt_reg + WCW'(1)) : '0;

      if (state_next == READ) grant_idx_reg <= arb_idx;
      if (state_reg == READ)  data_reg      <= input_event[grant_idx_reg];

      // Full is sampled while heading into LATCH; a stalled LATCH retries every cycle.
      load_reg <= (state_next == LATCH) && !shared_fifo_full;

      if (state_next == READ) begin
        read_n_reg <= ~arb_grant;
      end else if (state_next == FLUSH) begin
        read_n_reg <= ~pending;
      end else begin
        read_n_reg <= '1;
      end

      busy_reg <= (state_next != IDLE);

      if ((state_reg == INTEGRATE) && (state_next == FLUSH) && (drop_cnt_reg != '1)) begin
        drop_cnt_reg <= drop_cnt_reg + DROP_CNT_W'(1);
      end
    end
  end

  assign channel_event_out = data_reg;
  assign load_event        = load_reg;
  assign read_local_fifo_n = read_n_reg;
  assign busy              = busy_reg;
  assign dropped_events    = drop_cnt_reg;

endmodule

// File: tb/tb_event_router_rr.sv
// Bench for event_router_rr: channel FIFOs modelled as queues, expected load order from a window-level model.
module tb_event_router_rr;

  localparam int NCH    = 16;
  localparam int W      = 33;
  localparam int DW     = W - 1;
  localparam int HITW   = $clog2(NCH + 1);
  localparam int TIMERW = 8;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic [NCH-1:0][DW-1:0]   input_event;
  logic [NCH-1:0]           local_fifo_empty;
  logic [NCH-1:0]           channel_mask;
  logic                     lightpix_mode;
  logic [HITW-1:0]          hit_threshold;
  logic [TIMERW-1:0]        timeout;
  logic                     shared_fifo_full;
  logic [DW-1:0]            channel_event_out;
  logic                     load_event;
  logic [NCH-1:0]           read_local_fifo_n;
  logic                     busy;
  logic [15:0]              dropped_events;

  event_router_rr #(
    .WIDTH       (W),
    .NUMCHANNELS (NCH),
    .HITW        (HITW),
    .TIMERW      (TIMERW),
    .WAIT_CYCLES (3)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .input_event       (input_event),
    .local_fifo_empty  (local_fifo_empty),
    .channel_mask      (channel_mask),
    .lightpix_mode     (lightpix_mode),
    .hit_threshold     (hit_threshold),
    .timeout           (timeout),
    .shared_fifo_full  (shared_fifo_full),
    .channel_event_out (channel_event_out),
    .load_event        (load_event),
    .read_local_fifo_n (read_local_fifo_n),
    .busy              (busy),
    .dropped_events    (dropped_events)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fifo [NCH][$];
  logic [DW-1:0] exp_q [$];
  int            pop_cnt [NCH];
  int            load_cnt;
  int            first_pop_cyc;
  int            first_load_cyc;
  int            start_cyc;
  logic          busy_seen;
  logic [NCH-1:0] popped_any;
  int            model_last = NCH - 1;
  int            seq = 0;
  logic [DW-1:0] last_word;

  // Monitor: every load_event pops the scoreboard and compares.
  initial begin
    logic          prev_full;
    logic [DW-1:0] w;
    prev_full = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if ((read_local_fifo_n != '1) && (first_pop_cyc < 0)) first_pop_cyc = cyc;
        popped_any = popped_any | ~read_local_fifo_n;
        if (busy) busy_seen = 1'b1;
        if (load_event) begin
          load_cnt++;
          if (first_load_cyc < 0) first_load_cyc = cyc;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL load_data: unexpected load of %0h with empty scoreboard", channel_event_out);
          end else begin
            w = exp_q.pop_front();
            if (channel_event_out !== w) begin
              errors++;
              $display("FAIL load_data: got %0h expected %0h", channel_event_out, w);
            end else begin
              $display("load cycle %0d data %0h", cyc, w);
            end
          end
          checks++;
          if (prev_full) begin
            errors++;
            $display("FAIL load_after_full: load_event 1 but shared_fifo_full was 1 the cycle before");
          end
        end
      end
      prev_full = shared_fifo_full;
    end
  end

  initial begin
    #600us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int c = 0; c < NCH; c++) begin
      local_fifo_empty[c] = (fifo[c].size() == 0);
      input_event[c]      = (fifo[c].size() != 0) ? fifo[c][0] : '0;
    end
  endtask

  task automatic push(input int c);
    last_word = (DW'(c) << 24) | DW'(seq);
    seq++;
    fifo[c].push_back(last_word);
  endtask

  // One clock: pops strobed this cycle take effect just after the next edge.
  task automatic tick();
    logic [NCH-1:0] pops;
    @(negedge clk);
    pops = ~read_local_fifo_n;
    @(posedge clk);
    #1;
    if (reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        if (pops[c]) begin
          pop_cnt[c]++;
          if (fifo[c].size() != 0) void'(fifo[c].pop_front());
        end
      end
    end
    drive();
  endtask

  task automatic arm();
    first_pop_cyc  = -1;
    first_load_cyc = -1;
    load_cnt       = 0;
    busy_seen      = 1'b0;
    popped_any     = '0;
    for (int c = 0; c < NCH; c++) pop_cnt[c] = 0;
    start_cyc = cyc;
  endtask

  // Window model: every enabled non-empty channel is served once per window, in arbitration order.
  task automatic predict();
    int pos [NCH];
    int base;
    int c;
    bit any;
    for (int i = 0; i < NCH; i++) pos[i] = 0;
    forever begin
      any  = 1'b0;
      base = model_last;
      for (int k = 1; k <= NCH; k++) begin
`ifdef MADCAP_ROUTER_RR_EN
        c = (base + k) % NCH;
`else
        c = k - 1;
`endif
        if (channel_mask[c] && (pos[c] < fifo[c].size())) begin
          exp_q.push_back(fifo[c][pos[c]]);
          pos[c]++;
          any = 1'b1;
          model_last = c;
        end
      end
      if (!any) break;
    end
  endtask

  task automatic run_quiet(input int max_cycles, input bit rand_full);
    int q;
    q = 0;
    for (int i = 0; i < max_cycles; i++) begin
      if (rand_full) shared_fifo_full = ($urandom_range(0, 3) == 0);
      tick();
      if (!busy && ((~local_fifo_empty & channel_mask) == '0)) q++;
      else q = 0;
      if (q >= 4) begin
        shared_fifo_full = 1'b0;
        return;
      end
    end
    shared_fifo_full = 1'b0;
    checks++;
    errors++;
    $display("FAIL idle_wait: router still active after %0d cycles", max_cycles);
  endtask

  initial begin
    int bad;
    int leftover;
    logic [DW-1:0] w_hold;

    channel_mask     = '1;
    lightpix_mode    = 1'b0;
    hit_threshold    = '0;
    timeout          = '0;
    shared_fifo_full = 1'b0;
    drive();
    arm();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data", channel_event_out, 0);
    check("rst_load", load_event, 0);
    check("rst_read_n", read_local_fifo_n, 64'(16'hFFFF));
    check("rst_busy", busy, 0);
    check("rst_dropped", dropped_events, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) tick();

    // Mode 0, two channels: order, latency and single pops.
    arm();
    push(5);
    push(9);
    drive();
    predict();
    run_quiet(300, 1'b0);
    check("m0_pop_latency", first_pop_cyc - start_cyc, 3);
    check("m0_load_latency", first_load_cyc - start_cyc, 4);
    check("m0_load_count", load_cnt, 2);
    check("m0_pop_ch5", pop_cnt[5], 1);
    check("m0_pop_ch9", pop_cnt[9], 1);
    check("m0_sb_empty", exp_q.size(), 0);

    // Mode 1 below threshold: window expires and is flushed.
    lightpix_mode = 1'b1;
    hit_threshold = HITW'(3);
    timeout       = TIMERW'(10);
    arm();
    push(2);
    push(6);
    drive();
    run_quiet(300, 1'b0);
    check("flush_pop_cycle", first_pop_cyc - start_cyc, 12);
    check("flush_pop_ch2", pop_cnt[2], 1);
    check("flush_pop_ch6", pop_cnt[6], 1);
    check("flush_popped_set", popped_any, 64'(16'h0044));
    check("flush_no_load", load_cnt, 0);
    check("flush_dropped", dropped_events, 1);

    // Mode 1, third hit arrives inside the window: accepted.
    arm();
    push(1);
    push(3);
    drive();
    repeat (4) tick();
    push(11);
    drive();
    predict();
    run_quiet(300, 1'b0);
    check("thr_load_count", load_cnt, 3);
    check("thr_dropped", dropped_events, 1);
    check("thr_sb_empty", exp_q.size(), 0);

    // Threshold 0 behaves as 1.
    hit_threshold = '0;
    timeout       = TIMERW'(5);
    arm();
    push(12);
    drive();
    predict();
    run_quiet(300, 1'b0);
    check("thr0_load_latency", first_load_cyc - start_cyc, 4);
    check("thr0_load_count", load_cnt, 1);
    check("thr0_dropped", dropped_events, 1);

    // Timeout 0: flush after a single integrate cycle.
    hit_threshold = HITW'(3);
    timeout       = '0;
    arm();
    push(4);
    drive();
    run_quiet(300, 1'b0);
    check("to0_pop_cycle", first_pop_cyc - start_cyc, 2);
    check("to0_no_load", load_cnt, 0);
    check("to0_dropped", dropped_events, 2);

    // Masked channel is ignored entirely.
    lightpix_mode = 1'b0;
    channel_mask  = ~(NCH'(1) << 5);
    arm();
    push(5);
    drive();
    repeat (30) tick();
    check("mask_busy_seen", busy_seen, 0);
    check("mask_ch5_popped", popped_any[5], 0);
    check("mask_no_load", load_cnt, 0);
    channel_mask = '1;
    arm();
    drive();
    predict();
    run_quiet(300, 1'b0);
    check("unmask_load_count", load_cnt, 1);

    // Backpressure held in LATCH for 20 cycles, then released.
    shared_fifo_full = 1'b1;
    arm();
    push(4);
    w_hold = last_word;
    drive();
    predict();
    repeat (4) tick();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (load_event || (channel_event_out !== w_hold)) bad++;
      tick();
    end
    check("bp_hold_stable", bad, 0);
    shared_fifo_full = 1'b0;
    run_quiet(300, 1'b0);
    check("bp_load_count", load_cnt, 1);
    check("bp_sb_empty", exp_q.size(), 0);

    // Channel 0 always pending alongside channel 7.
    arm();
    repeat (4) push(0);
    repeat (2) push(7);
    drive();
    predict();
    run_quiet(600, 1'b0);
    check("arb_load_count", load_cnt, 6);
    check("arb_sb_empty", exp_q.size(), 0);

    // Randomized traffic with random masks and backpressure.
    for (int it = 0; it < 12; it++) begin
      channel_mask = NCH'($urandom);
      for (int c = 0; c < NCH; c++) begin
        repeat ($urandom_range(0, 2)) push(c);
      end
      drive();
      arm();
      predict();
      run_quiet(3000, 1'b1);
      check("rand_sb_empty", exp_q.size(), 0);
      leftover = 0;
      for (int c = 0; c < NCH; c++) if (channel_mask[c]) leftover += fifo[c].size();
      check("rand_enabled_drained", leftover, 0);
    end
    channel_mask = '1;
    arm();
    drive();
    predict();
    run_quiet(3000, 1'b0);
    check("drain_sb_empty", exp_q.size(), 0);

    // Asynchronous reset while stalled in LATCH.
    shared_fifo_full = 1'b1;
    arm();
    push(8);
    drive();
    predict();
    repeat (6) tick();
    reset_n = 1'b0;
    #1;
    check("arst_data", channel_event_out, 0);
    check("arst_load", load_event, 0);
    check("arst_read_n", read_local_fifo_n, 64'(16'hFFFF));
    check("arst_busy", busy, 0);
    check("arst_dropped", dropped_events, 0);
    exp_q.delete();
    model_last       = NCH - 1;
    shared_fifo_full = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    arm();
    repeat (10) tick();
    check("post_rst_no_load", load_cnt, 0);
    check("post_rst_no_pop", popped_any, 0);
    check("post_rst_idle", busy_seen, 0);

    arm();
    push(15);
    drive();
    predict();
    run_quiet(300, 1'b0);
    check("post_rst_load_latency", first_load_cyc - start_cyc, 4);
    check("post_rst_load_count", load_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
